// File: rtl/wb_uart_rx_pkg.sv
// rtl/wb_uart_rx_pkg.sv - shared UART register map, STATUS layout, FSM encoding and divisor floor
package wb_uart_rx_pkg;

    localparam logic [1:0] REG_RXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_OVERRUN   = 1;
    localparam int STAT_FRAME_ERR = 2;
    localparam int STAT_FULL      = 3;
    localparam int STAT_COUNT_LSB = 4;

    localparam logic [15:0] DIV_MIN = 16'd4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    function automatic logic [15:0] div_floor(input logic [15:0] div);
        return (div < DIV_MIN) ? DIV_MIN : div;
    endfunction

endpackage

// File: rtl/wb_uart_rx_core.sv
// rtl/wb_uart_rx_core.sv - input synchronizer, bit timer and 8N1 receive FSM
module wb_uart_rx_core
    import wb_uart_rx_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        i_rx,
    input  logic        i_en,
    input  logic [15:0] i_div,
    output logic [7:0]  o_byte,
    output logic        o_valid,
    output logic        o_frame_err
);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_prev;
    logic [1:0]  r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_div;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        r_valid;
    logic        r_ferr;

    logic        w_fall;
    logic        w_expire;
    logic [15:0] w_div_eff;

    assign w_fall    = r_prev & ~r_sync2;
    // A count of 1 marks the sample cycle, so a reload of div gives exactly div cycles per bit.
    assign w_expire  = (r_cnt == 16'd1);
    assign w_div_eff = div_floor(i_div);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_div   <= DIV_MIN;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            if (r_state != S_IDLE && !i_en) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_fall && i_en) begin
                            r_state <= S_START;
                            r_div   <= w_div_eff;
                            r_cnt   <= w_div_eff >> 1;
                        end
                    end
                    S_START: begin
                        if (w_expire) begin
                            if (r_sync2) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_state <= S_DATA;
                                r_cnt   <= r_div;
                                r_bit   <= '0;
                            end
                        end else begin
                            r_cnt <= r_cnt - 16'd1;
                        end
                    end
                    S_DATA: begin
                        if (w_expire) begin
                            r_shift <= {r_sync2, r_shift[7:1]};
                            r_cnt   <= r_div;
                            r_bit   <= r_bit + 3'd1;
                            if (r_bit == 3'd7) begin
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_cnt <= r_cnt - 16'd1;
                        end
                    end
                    S_STOP: begin
                        if (w_expire) begin
                            r_state <= S_IDLE;
                            if (r_sync2) begin
                                r_valid <= 1'b1;
                            end else begin
                                r_ferr <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt - 16'd1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_byte      = r_shift;
    assign o_valid     = r_valid;
    assign o_frame_err = r_ferr;

endmodule

// File: rtl/wb_uart_rx.sv
// rtl/wb_uart_rx.sv - Wishbone UART receiver: receive FIFO, status/divisor/control registers, irq
module wb_uart_rx
    import wb_uart_rx_pkg::*;
#(
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 32,
    parameter int CLK_DIV       = 434,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
    input  logic [3:0]               wb_sel_i,
    input  logic                     wb_we_i,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    output logic                     wb_ack_o,
    output logic [WB_DATA_WIDTH-1:0] wb_data_o,
    input  logic                     uart_rx_i,
    output logic                     irq_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic                     r_ack;
    logic [WB_DATA_WIDTH-1:0] r_rdata;
    logic                     r_irq;
    logic [15:0]              r_div;
    logic                     r_en;
    logic                     r_irq_en;
    logic                     r_ovr;
    logic                     r_ferr;
    logic [7:0]               r_mem [FIFO_DEPTH];
    logic [PW-1:0]            r_wptr;
    logic [PW-1:0]            r_rptr;
    logic [CW-1:0]            r_count;

    logic                     w_req;
    logic                     w_wr;
    logic                     w_pop;
    logic                     w_full;
    logic                     w_not_empty;
    logic                     w_push_ok;
    logic                     w_set_ovr;
    logic                     w_clr_ovr;
    logic                     w_clr_ferr;
    logic [7:0]               w_byte;
    logic                     w_valid;
    logic                     w_core_ferr;
    logic [7:0]               w_status;
    logic [WB_DATA_WIDTH-1:0] w_rdata;
    logic                     w_unused;

    assign w_unused = ^{wb_sel_i, wb_addr_i[WB_ADDR_WIDTH-1:4], wb_addr_i[1:0],
                        wb_data_i[WB_DATA_WIDTH-1:16]};

    wb_uart_rx_core u_core (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .i_rx        (uart_rx_i),
        .i_en        (r_en),
        .i_div       (r_div),
        .o_byte      (w_byte),
        .o_valid     (w_valid),
        .o_frame_err (w_core_ferr)
    );

    // Requests are decoded on the edge that raises ack, so side effects are visible in the ack cycle.
    assign w_req       = wb_stb_i & wb_cyc_i & ~r_ack;
    assign w_wr        = w_req & wb_we_i;
    assign w_not_empty = (r_count != '0);
    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign w_pop       = w_req & ~wb_we_i & (wb_addr_i[3:2] == REG_RXDATA) & w_not_empty;
    assign w_push_ok   = w_valid & (~w_full | w_pop);
    assign w_set_ovr   = w_valid & w_full & ~w_pop;
    assign w_clr_ovr   = w_wr & (wb_addr_i[3:2] == REG_STATUS) & wb_data_i[STAT_OVERRUN];
    assign w_clr_ferr  = w_wr & (wb_addr_i[3:2] == REG_STATUS) & wb_data_i[STAT_FRAME_ERR];

    always_comb begin
        w_status                      = '0;
        w_status[STAT_NOT_EMPTY]      = w_not_empty;
        w_status[STAT_OVERRUN]        = r_ovr;
        w_status[STAT_FRAME_ERR]      = r_ferr;
        w_status[STAT_FULL]           = w_full;
        w_status[STAT_COUNT_LSB +: 4] = 4'(r_count);
    end

    always_comb begin
        w_rdata = '0;
        case (wb_addr_i[3:2])
            REG_RXDATA:  if (w_not_empty) w_rdata[7:0] = r_mem[r_rptr];
            REG_STATUS:  w_rdata[7:0]  = w_status;
            REG_DIVISOR: w_rdata[15:0] = r_div;
            REG_CTRL:    w_rdata[1:0]  = {r_irq_en, r_en};
            default:     w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= w_byte;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ack    <= 1'b0;
            r_rdata  <= '0;
            r_irq    <= 1'b0;
            r_div    <= 16'(CLK_DIV);
            r_en     <= 1'b1;
            r_irq_en <= 1'b0;
            r_ovr    <= 1'b0;
            r_ferr   <= 1'b0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
        end else begin
            r_ack   <= w_req;
            r_rdata <= w_req ? w_rdata : '0;
            r_irq   <= r_irq_en & (w_not_empty | r_ovr | r_ferr);
            if (w_wr && wb_addr_i[3:2] == REG_DIVISOR) begin
                r_div <= wb_data_i[15:0];
            end
            if (w_wr && wb_addr_i[3:2] == REG_CTRL) begin
                r_en     <= wb_data_i[0];
                r_irq_en <= wb_data_i[1];
            end
            // A new event in the same cycle as its W1C wins, so no error is ever lost.
            r_ovr  <= (r_ovr & ~w_clr_ovr) | w_set_ovr;
            r_ferr <= (r_ferr & ~w_clr_ferr) | w_core_ferr;
            if (w_push_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign wb_ack_o  = r_ack;
    assign wb_data_o = r_rdata;
    assign irq_o     = r_irq;

endmodule

// File: tb/tb_wb_uart_rx.sv
// tb/tb_wb_uart_rx.sv - scoreboard bench for wb_uart_rx
module tb_wb_uart_rx;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] wb_addr_i;
    logic [31:0] wb_data_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_ack_o;
    logic [31:0] wb_data_o;
    logic        uart_rx_i;
    logic        irq_o;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        chk;
        logic [31:0] val;
        int          tag;
    } exp_t;

    exp_t sb[$];

    wb_uart_rx dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wb_addr_i (wb_addr_i),
        .wb_data_i (wb_data_i),
        .wb_sel_i  (wb_sel_i),
        .wb_we_i   (wb_we_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_stb_i  (wb_stb_i),
        .wb_ack_o  (wb_ack_o),
        .wb_data_o (wb_data_o),
        .uart_rx_i (uart_rx_i),
        .irq_o     (irq_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (rst_ni && wb_ack_o) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_ack got ack=1 want no ack");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk) begin
                    n_checks++;
                    if (wb_data_o !== e.val) begin
                        n_errors++;
                        $display("FAIL read_tag%0d got %h want %h", e.tag, wb_data_o, e.val);
                    end
                end
            end
        end
    end

    task automatic chk_bit(input string nm, input logic got, input logic want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got %b want %b", nm, got, want);
        end
    endtask

    // All bus and line tasks start and end one time unit after a rising edge.
    task automatic bus(input logic w, input logic [3:0] a, input logic [31:0] d,
                       input logic [31:0] exp, input int tag);
        exp_t e;
        e.chk = ~w;
        e.val = exp;
        e.tag = tag;
        sb.push_back(e);
        wb_addr_i = {28'd0, a};
        wb_data_i = d;
        wb_we_i   = w;
        wb_cyc_i  = 1'b1;
        wb_stb_i  = 1'b1;
        @(posedge clk_i);
        #1;
        n_checks++;
        if (wb_ack_o !== 1'b1) begin
            n_errors++;
            $display("FAIL ack_tag%0d got %b want 1", tag, wb_ack_o);
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input int tag);
        bus(1'b0, a, 32'd0, exp, tag);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus(1'b1, a, d, 32'd0, 0);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input int div);
        uart_rx_i = 1'b0;
        cycles(div);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            cycles(div);
        end
        uart_rx_i = stop;
        cycles(div);
        uart_rx_i = 1'b1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni    = 1'b0;
        wb_addr_i = '0;
        wb_data_i = '0;
        wb_sel_i  = 4'hF;
        wb_we_i   = 1'b0;
        wb_cyc_i  = 1'b0;
        wb_stb_i  = 1'b0;
        uart_rx_i = 1'b1;
        cycles(4);
        chk_bit("reset_ack", wb_ack_o, 1'b0);
        chk_bit("reset_data", (wb_data_o == 32'd0), 1'b1);
        chk_bit("reset_irq", irq_o, 1'b0);
        rst_ni = 1'b1;
        cycles(1);

        // 1: register reset values
        rd(4'h4, 32'h0000_0000, 10);
        rd(4'h8, 32'd434, 11);
        rd(4'hC, 32'h0000_0001, 12);
        rd(4'h0, 32'h0000_0000, 13);
        chk_bit("t1_irq", irq_o, 1'b0);

        // 2: single byte at 16 clk/bit
        wr(4'h8, 32'd16);
        rd(4'h8, 32'd16, 20);
        send(8'hA5, 1'b1, 16);
        cycles(16);
        rd(4'h4, 32'h0000_0011, 21);
        rd(4'h0, 32'h0000_00A5, 22);
        rd(4'h4, 32'h0000_0000, 23);

        // 3: overrun on a fifth byte
        for (int i = 1; i <= 5; i++) begin
            send(8'(i), 1'b1, 16);
            cycles(16);
        end
        rd(4'h4, 32'h0000_004B, 30);
        for (int i = 1; i <= 4; i++) begin
            rd(4'h0, 32'(i), 30 + i);
        end
        rd(4'h4, 32'h0000_0002, 35);
        wr(4'h4, 32'h0000_0002);
        rd(4'h4, 32'h0000_0000, 36);

        // 4: framing error then a clean frame
        send(8'h3C, 1'b0, 16);
        cycles(32);
        rd(4'h4, 32'h0000_0004, 40);
        send(8'h7E, 1'b1, 16);
        cycles(16);
        rd(4'h4, 32'h0000_0015, 41);
        rd(4'h0, 32'h0000_007E, 42);
        wr(4'h4, 32'h0000_0004);
        rd(4'h4, 32'h0000_0000, 43);

        // 5: short glitch is rejected
        uart_rx_i = 1'b0;
        cycles(5);
        uart_rx_i = 1'b1;
        cycles(200);
        rd(4'h4, 32'h0000_0000, 50);

        // 6: push and pop on the same edge with a full FIFO
        wr(4'hC, 32'h0000_0003);
        chk_bit("t6_irq_idle", irq_o, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            send(8'(8'h11 * i), 1'b1, 16);
            cycles(16);
        end
        chk_bit("t6_irq_full", irq_o, 1'b1);
        fork
            send(8'h55, 1'b1, 16);
            begin
                cycles(155);
                rd(4'h0, 32'h0000_0011, 60);
            end
        join
        cycles(16);
        rd(4'h4, 32'h0000_0049, 61);
        chk_bit("t6_irq_after", irq_o, 1'b1);
        rd(4'h0, 32'h0000_0022, 62);
        rd(4'h0, 32'h0000_0033, 63);
        rd(4'h0, 32'h0000_0044, 64);
        chk_bit("t6_irq_before_last", irq_o, 1'b1);
        wb_addr_i = 32'h0;
        wb_we_i   = 1'b0;
        begin
            exp_t e;
            e.chk = 1'b1;
            e.val = 32'h0000_0055;
            e.tag = 65;
            sb.push_back(e);
        end
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk_bit("t6_ack_last", wb_ack_o, 1'b1);
        chk_bit("t6_irq_at_pop", irq_o, 1'b1);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk_bit("t6_irq_cleared", irq_o, 1'b0);
        rd(4'h4, 32'h0000_0000, 66);

        cycles(4);
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
